// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the command-master FSM
// state encoding. Imported by axil_cmd_master.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns one command (read or write) into a single AXI-Lite
// transaction and returns the outcome on a response channel. Only one
// transaction is ever outstanding.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_*               command channel (valid/ready), cmd_write=1 is a write
//   rsp_*               response channel (valid/ready): rdata, resp, timeout
//   m_axi_*             AXI-Lite master (AW, W, B, AR, R); all outputs registered
//
// Build option
//   AXIL_MASTER_TIMEOUT_EN  when defined, a transaction not answered within
//                           TIMEOUT_CYC cycles is aborted and reported as
//                           SLVERR with rsp_timeout=1. Otherwise the master
//                           waits forever and rsp_timeout stays 0.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e state;
  logic   resp_hs;   // B or R handshake this cycle
  logic   expired;   // transaction budget used up this cycle

  // bready/rready are only ever high in their own state, so valid alone
  // in that state is the handshake.
  assign resp_hs = ((state == WR_RESP) && m_axi_bvalid) ||
                   ((state == RD_DATA) && m_axi_rvalid);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             busy;

  assign busy    = (state != IDLE) && (state != RSP);
  // Counter holds k-1 going into the k-th edge after the command handshake,
  // so expiry lands exactly TIMEOUT_CYC edges after leaving IDLE.
  assign expired = busy && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             to_cnt <= '0;
    else if (state == IDLE) to_cnt <= '0;
    else if (busy)          to_cnt <= to_cnt + 1'b1;
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else if (expired && !resp_hs) begin
      // Abort: a response arriving on the expiry cycle takes precedence.
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b1;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_SLVERR;
      rsp_timeout   <= 1'b1;
      state         <= RSP;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently; leave once neither is pending.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a delay-configurable AXI-Lite slave, a channel
// monitor with protocol checks, and directed plus randomized scenarios
// compared against an expected-transaction model.
module tb_axil_cmd_master;
  localparam int TO = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        s_awready = 0, s_wready = 0, s_arready = 0, s_bvalid = 0, s_rvalid = 0;
  logic [1:0]  s_bresp = 0, s_rresp = 0;
  logic [31:0] s_rdata = 0;
  logic        stray_b = 0, stray_r = 0;
  logic        m_bvalid, m_rvalid;
  assign m_bvalid = s_bvalid | stray_b;
  assign m_rvalid = s_rvalid | stray_r;

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(s_awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(s_wready),
    .m_axi_bresp(s_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(s_arready),
    .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(rready)
  );

  logic [141:0] all_out;
  assign all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, awaddr, awvalid,
                    wdata, wstrb, wvalid, bready, araddr, arvalid, rready};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // ---------------- slave configuration ----------------
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit b_never = 0;
  logic [1:0]  b_resp_cfg = 0, r_resp_cfg = 0;
  logic [31:0] r_data_cfg = 0;

  // ---------------- monitor ----------------
  int n_aw, n_w, n_b, n_ar, n_r;
  logic [31:0] aw_q[$], w_q[$], ar_q[$];
  logic [3:0]  ws_q[$];
  logic        p_awv, p_wv, p_arv;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      aw_q.delete(); w_q.delete(); ar_q.delete(); ws_q.delete();
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      if (p_awv) begin
        n_chk++;
        if (!awvalid || awaddr !== p_awaddr) begin
          n_fail++; $display("FAIL aw_stable: awvalid=%0b awaddr=%h, required 1/%h", awvalid, awaddr, p_awaddr);
        end
      end
      if (p_wv) begin
        n_chk++;
        if (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb) begin
          n_fail++; $display("FAIL w_stable: wvalid=%0b wdata=%h, required 1/%h", wvalid, wdata, p_wdata);
        end
      end
      if (p_arv) begin
        n_chk++;
        if (!arvalid || araddr !== p_araddr) begin
          n_fail++; $display("FAIL ar_stable: arvalid=%0b araddr=%h, required 1/%h", arvalid, araddr, p_araddr);
        end
      end
      if (awvalid || wvalid || arvalid) begin
        n_chk++;
        if ((awvalid || wvalid) && arvalid) begin
          n_fail++; $display("FAIL valid_overlap: aw=%0b w=%0b ar=%0b, required no write/read overlap", awvalid, wvalid, arvalid);
        end
      end
      if (awvalid && s_awready) begin n_aw++; aw_q.push_back(awaddr); end
      if (wvalid && s_wready) begin n_w++; w_q.push_back(wdata); ws_q.push_back(wstrb); end
      if (arvalid && s_arready) begin n_ar++; ar_q.push_back(araddr); end
      if (m_bvalid && bready) n_b++;
      if (m_rvalid && rready) n_r++;
      p_awv = awvalid && !s_awready; p_awaddr = awaddr;
      p_wv  = wvalid && !s_wready;   p_wdata = wdata; p_wstrb = wstrb;
      p_arv = arvalid && !s_arready; p_araddr = araddr;
    end
  end

  // ---------------- slave: drives on the falling edge ----------------
  int aw_wait, w_wait, ar_wait, b_wait, r_wait, b_issued, r_issued;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0;
      s_bresp = 0; s_rresp = 0; s_rdata = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; b_issued = 0; r_issued = 0;
    end else begin
      if (awvalid) begin s_awready = (aw_wait >= aw_dly); aw_wait++; end else begin s_awready = 0; aw_wait = 0; end
      if (wvalid)  begin s_wready  = (w_wait  >= w_dly);  w_wait++;  end else begin s_wready  = 0; w_wait  = 0; end
      if (arvalid) begin s_arready = (ar_wait >= ar_dly); ar_wait++; end else begin s_arready = 0; ar_wait = 0; end
      if (s_bvalid && n_b == b_issued) s_bvalid = 0;
      if (!s_bvalid && !b_never && ((n_aw < n_w ? n_aw : n_w) > b_issued)) begin
        if (b_wait >= b_dly) begin s_bvalid = 1; s_bresp = b_resp_cfg; b_issued++; b_wait = 0; end
        else b_wait++;
      end
      if (s_rvalid && n_r == r_issued) s_rvalid = 0;
      if (!s_rvalid && n_ar > r_issued) begin
        if (r_wait >= r_dly) begin
          s_rvalid = 1; s_rdata = r_data_cfg; s_rresp = r_resp_cfg; r_issued++; r_wait = 0;
        end else r_wait++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 0; cmd_valid = 0; rsp_ready = 0; stray_b = 0; stray_r = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0; b_never = 0;
    b_resp_cfg = 0; r_resp_cfg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Returns hs = index of the clock edge on which the command handshake happened.
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int hs);
    int n = 0;
    hs = -1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    n_chk++;
    if (!cmd_ready) begin
      n_fail++; $display("FAIL cmd_handshake: cmd_ready=%0b, required 1", cmd_ready);
      cmd_valid = 0;
    end else begin
      @(posedge clk); #1;
      hs = cyc; cmd_valid = 0;
    end
  endtask

  // vc = index of the edge that registered rsp_valid; holds rsp_ready low for
  // 'stall' cycles checking the response stays put, then accepts it.
  task automatic get_rsp(input int stall, output logic [31:0] rd, output logic [1:0] rr,
                         output logic to, output int vc);
    int n = 0;
    vc = -1; rd = 0; rr = 0; to = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    n_chk++;
    if (!rsp_valid) begin
      n_fail++; $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n);
    end else begin
      vc = cyc; rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        n_chk++;
        if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, rd, rr, to}) begin
          n_fail++; $display("FAIL rsp_hold: valid=%0b rdata=%h resp=%0d, required 1/%h/%0d",
                             rsp_valid, rsp_rdata, rsp_resp, rd, rr);
        end
      end
      rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: %h, required 0", all_out); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: cmd_ready=%0b rsp_valid=%0b, required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_basic();
    int hs, vc; logic [31:0] rd; logic [1:0] rr; logic to;
    send_cmd(1, 32'h4, 32'h0, 4'hF, hs);
    get_rsp(0, rd, rr, to, vc);
    // rsp_valid registered on edge N+2, so it is presented for edge N+3.
    n_chk++; if (vc != hs + 2) begin n_fail++; $display("FAIL wr_latency: %0d, required %0d", vc - hs, 2); end
    n_chk++; if ({rd, rr, to} !== {32'h0, 2'b00, 1'b0}) begin n_fail++; $display("FAIL wr_rsp: rdata=%h resp=%0d to=%0b, required 0/0/0", rd, rr, to); end
    n_chk++;
    if (n_aw != 1 || n_w != 1 || n_b != 1 || aw_q[0] !== 32'h4 || w_q[0] !== 32'h0 || ws_q[0] !== 4'hF) begin
      n_fail++; $display("FAIL wr_beats: aw=%0d w=%0d b=%0d, required 1/1/1 addr 4 data 0 strb F", n_aw, n_w, n_b);
    end
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_to_idle: cmd_ready=%0b, required 1", cmd_ready); end
  endtask

  task automatic test_w_before_aw();
    int hs, vc; logic [31:0] rd; logic [1:0] rr; logic to;
    apply_reset();
    aw_dly = 3; w_dly = 0;
    send_cmd(1, 32'h10, 32'hA5A5_0001, 4'hF, hs);
    @(negedge clk); @(negedge clk);  // after edge N+1: W done, AW still waiting
    n_chk++;
    if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
      n_fail++; $display("FAIL w_first_valids: wvalid=%0b awvalid=%0b, required 0/1", wvalid, awvalid);
    end
    get_rsp(0, rd, rr, to, vc);
    repeat (5) @(negedge clk);
    n_chk++; if (n_b != 1 || n_aw != 1 || n_w != 1 || rr !== 2'b00) begin
      n_fail++; $display("FAIL w_first_beats: b=%0d aw=%0d w=%0d resp=%0d, required 1/1/1/0", n_b, n_aw, n_w, rr);
    end
  endtask

  task automatic test_aw_before_w();
    int hs, vc; logic [31:0] rd; logic [1:0] rr; logic to;
    apply_reset();
    w_dly = 2; b_resp_cfg = 2'b01;
    send_cmd(1, 32'h20, 32'h1234_5678, 4'h3, hs);
    get_rsp(0, rd, rr, to, vc);
    n_chk++; if (rr !== 2'b01 || w_q[0] !== 32'h1234_5678 || ws_q[0] !== 4'h3 || n_b != 1) begin
      n_fail++; $display("FAIL aw_first: resp=%0d wdata=%h b=%0d, required 1/12345678/1", rr, w_q[0], n_b);
    end
  endtask

  task automatic test_read();
    int hs, vc; logic [31:0] rd; logic [1:0] rr; logic to;
    apply_reset();
    r_dly = 5; r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b00;
    send_cmd(0, 32'h0, 32'h0, 4'h0, hs);
    get_rsp(4, rd, rr, to, vc);
    n_chk++; if (rd !== 32'hDEAD_BEEF || rr !== 2'b00 || to !== 1'b0) begin
      n_fail++; $display("FAIL rd_data: rdata=%h resp=%0d, required DEADBEEF/0", rd, rr);
    end
    n_chk++; if (n_ar != 1 || ar_q[0] !== 32'h0 || n_aw != 0 || n_r != 1) begin
      n_fail++; $display("FAIL rd_beats: ar=%0d aw=%0d r=%0d, required 1/0/1", n_ar, n_aw, n_r);
    end
  endtask

  task automatic test_stray();
    stray_b = 1; stray_r = 1;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bready !== 1'b0 || rready !== 1'b0) begin
        n_fail++; $display("FAIL stray_resp: cmd_ready=%0b rsp_valid=%0b, required 1/0", cmd_ready, rsp_valid);
      end
    end
    stray_b = 0; stray_r = 0;
  endtask

  task automatic test_timeout();
    int hs, vc; logic [31:0] rd; logic [1:0] rr; logic to;
    apply_reset();
    b_never = 1;
    send_cmd(1, 32'h8, 32'h5, 4'hF, hs);
`ifdef AXIL_MASTER_TIMEOUT_EN
    while (cyc < hs + TO - 1) @(negedge clk);
    n_chk++; if (bready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL to_before: bready=%0b rsp_valid=%0b, required 1/0", bready, rsp_valid);
    end
    @(negedge clk);
    n_chk++; if ({bready, rsp_valid, rsp_resp, rsp_timeout} !== {1'b0, 1'b1, 2'b10, 1'b1}) begin
      n_fail++; $display("FAIL to_expire: bready=%0b valid=%0b resp=%0d to=%0b, required 0/1/2/1",
                         bready, rsp_valid, rsp_resp, rsp_timeout);
    end
    rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
`else
    repeat (40) @(negedge clk);
    n_chk++; if (bready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout_wait: bready=%0b rsp_valid=%0b, required 1/0", bready, rsp_valid);
    end
    b_never = 0;
    get_rsp(0, rd, rr, to, vc);
    n_chk++; if (rr !== 2'b00 || to !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout_rsp: resp=%0d to=%0b, required 0/0", rr, to);
    end
`endif
    apply_reset();
    // B lands on edge N+TO: in a timeout build it coincides with expiry and wins.
    b_dly = TO - 2; b_resp_cfg = 2'b01;
    send_cmd(1, 32'hC, 32'h6, 4'hF, hs);
    get_rsp(0, rd, rr, to, vc);
    n_chk++; if (rr !== 2'b01 || to !== 1'b0 || vc != hs + TO) begin
      n_fail++; $display("FAIL to_race: resp=%0d to=%0b lat=%0d, required 1/0/%0d", rr, to, vc - hs, TO);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    apply_reset();
    aw_dly = 20;
    send_cmd(1, 32'h4, 32'h9, 4'hF, hs);
    @(negedge clk); @(negedge clk);
    n_chk++; if (awvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: awvalid=%0b, required 1", awvalid); end
    rst_n = 0; #1;
    n_chk++; if (all_out !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: %h, required 0", all_out); end
    @(negedge clk); @(negedge clk);
    aw_dly = 0; rst_n = 1;
    repeat (20) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0 || awvalid !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL mid_after: rsp_valid=%0b awvalid=%0b cmd_ready=%0b, required 0/0/1", rsp_valid, awvalid, cmd_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_t[3], d_t[3];
    int hs[3], vc[3];
    apply_reset();
    a_t[0] = 32'h4; a_t[1] = 32'h0; a_t[2] = 32'h0;
    d_t[0] = 32'h0; d_t[1] = 32'h1; d_t[2] = 32'h2;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      send_cmd(1, a_t[i], d_t[i], 4'hF, hs[i]);
      @(negedge clk);
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      vc[i] = cyc;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || vc[i] != hs[i] + 2) begin
        n_fail++; $display("FAIL b2b_rsp%0d: valid=%0b resp=%0d lat=%0d, required 1/0/2", i, rsp_valid, rsp_resp, vc[i] - hs[i]);
      end
      if (i > 0) begin
        n_chk++; if (hs[i] != vc[i-1] + 2) begin
          n_fail++; $display("FAIL b2b_gap%0d: %0d, required %0d", i, hs[i] - vc[i-1], 2);
        end
      end
    end
    rsp_ready = 0;
    @(negedge clk);
    n_chk++; if (n_b != 3 || n_aw != 3 || n_w != 3) begin
      n_fail++; $display("FAIL b2b_counts: b=%0d aw=%0d w=%0d, required 3/3/3", n_b, n_aw, n_w);
    end
    for (int i = 0; i < 3 && i < aw_q.size() && i < w_q.size(); i++) begin
      n_chk++; if (aw_q[i] !== a_t[i] || w_q[i] !== d_t[i]) begin
        n_fail++; $display("FAIL b2b_order%0d: addr=%h data=%h, required %h/%h", i, aw_q[i], w_q[i], a_t[i], d_t[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e_aw[$], e_wd[$], e_ar[$];
    logic [3:0]  e_ws[$];
    apply_reset();
    for (int k = 0; k < 25; k++) begin
      int hs, vc;
      logic [31:0] rd, a, d; logic [1:0] rr, er; logic to, wr; logic [3:0] s;
      logic [31:0] erd;
      wr = 1'($urandom_range(0, 1));
      a = $urandom & 32'hFFFF_FFFC; d = $urandom; s = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
      r_data_cfg = $urandom;
      if (wr) begin
        e_aw.push_back(a); e_wd.push_back(d); e_ws.push_back(s);
        erd = 32'h0; er = b_resp_cfg;
      end else begin
        e_ar.push_back(a);
        erd = r_data_cfg; er = r_resp_cfg;
      end
      send_cmd(wr, a, d, s, hs);
      get_rsp($urandom_range(0, 3), rd, rr, to, vc);
      n_chk++; if (rd !== erd || rr !== er || to !== 1'b0) begin
        n_fail++; $display("FAIL rand_rsp%0d: rdata=%h resp=%0d to=%0b, required %h/%0d/0", k, rd, rr, to, erd, er);
      end
    end
    n_chk++; if (aw_q.size() != e_aw.size() || w_q.size() != e_wd.size() || ar_q.size() != e_ar.size()) begin
      n_fail++; $display("FAIL rand_counts: aw=%0d w=%0d ar=%0d, required %0d/%0d/%0d",
                         aw_q.size(), w_q.size(), ar_q.size(), e_aw.size(), e_wd.size(), e_ar.size());
    end else begin
      for (int i = 0; i < e_aw.size(); i++) begin
        n_chk++; if (aw_q[i] !== e_aw[i] || w_q[i] !== e_wd[i] || ws_q[i] !== e_ws[i]) begin
          n_fail++; $display("FAIL rand_wr%0d: %h/%h/%h, required %h/%h/%h", i, aw_q[i], w_q[i], ws_q[i], e_aw[i], e_wd[i], e_ws[i]);
        end
      end
      for (int i = 0; i < e_ar.size(); i++) begin
        n_chk++; if (ar_q[i] !== e_ar[i]) begin
          n_fail++; $display("FAIL rand_rd%0d: %h, required %h", i, ar_q[i], e_ar[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_stray();
    test_w_before_aw();
    test_aw_before_w();
    test_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the cycles allowed per transaction before abort.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1; 1 = write), cmd_addr (in, ADDR_W), cmd_wdata (in, DATA_W) and cmd_wstrb (in, 4).
REQ-007 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, DATA_W), rsp_resp (out, 2) and rsp_timeout (out, 1).
REQ-008 SHALL have the AXI-Lite master ports m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready and m_axi_rdata/rresp/rvalid/rready, with the standard widths and directions.

Function
REQ-009 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP.
REQ-010 SHALL drive cmd_ready high only in IDLE; a cmd_valid&&cmd_ready handshake latches the command and moves to WR_REQ if cmd_write is 1, otherwise to RD_REQ.
REQ-011 SHALL register every AXI output; awvalid, wvalid and arvalid first assert on the cycle after the command handshake.
REQ-012 SHALL, in WR_REQ, assert awvalid and wvalid together and drop each one independently on its own handshake, moving to WR_RESP once both handshakes are done.
REQ-013 SHALL accept aw and w handshakes in the same cycle, or in either order.
REQ-014 SHALL, in RD_REQ, hold arvalid high until arready, then move to RD_DATA.
REQ-015 SHALL hold bready high in WR_RESP and rready high in RD_DATA, and never assert them in other states.
REQ-016 SHALL never assert awvalid or wvalid together with arvalid, and SHALL allow only one outstanding transaction.
REQ-017 SHALL never change a VALID-qualified address or data while it waits for READY.
REQ-018 SHALL, on a B handshake, capture bresp into rsp_resp and clear rsp_rdata to 0; on an R handshake it SHALL capture rdata and rresp; in both cases it SHALL then enter RSP.
REQ-019 SHALL assert rsp_valid in RSP and hold rsp_valid, rsp_rdata, rsp_resp and rsp_timeout stable until rsp_ready, then return to IDLE.
REQ-020 SHALL allow a new command handshake on the cycle after the rsp handshake.
REQ-021 SHALL achieve a minimum latency, with an always-ready slave, of command handshake at edge N to rsp_valid at edge N+3.
REQ-022 SHALL ignore unexpected bvalid or rvalid outside WR_RESP and RD_DATA, with no state change.

Reset
REQ-023 SHALL, while rst_n is low, force state to IDLE and all valid/ready outputs to 0, and force rsp_rdata, rsp_resp, rsp_timeout and all AXI address/data/strobe outputs to 0.
REQ-024 SHALL make reset assertion mid-transaction abandon the transaction immediately, with no response produced.

Configuration
REQ-025 SHALL compile the timeout logic in only when AXIL_MASTER_TIMEOUT_EN is defined.
REQ-026 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, start a counter on leaving IDLE; when it reaches TIMEOUT_CYC before the B or R handshake, all AXI valid/ready outputs drop, rsp_resp becomes 2'b10 (SLVERR), rsp_timeout becomes 1 and the FSM enters RSP.
REQ-027 SHALL, when the B or R handshake and timeout expiry fall in the same cycle, let the handshake win and leave rsp_timeout at 0.
REQ-028 SHALL, without AXIL_MASTER_TIMEOUT_EN, wait indefinitely and tie rsp_timeout to 0.

Structure
REQ-029 SHALL place the AXI response codes (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state enum in the shared package axil_pkg.
REQ-030 SHALL be a single module with no sub-module; the timeout counter stays inline.

Verification
REQ-031 SHALL cover: always-ready slave, write addr 0x4 data 0x0 -> one aw and one w beat with wstrb 0xF, rsp_valid at N+3, rsp_resp 0.
REQ-032 SHALL cover: slave asserts wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds, exactly one B accepted, rsp_resp 0.
REQ-033 SHALL cover: read addr 0x0, slave returns 0xDEADBEEF with rresp 2'b00 after 5 cycles -> rsp_rdata 0xDEADBEEF; rsp_valid held stable while rsp_ready is low for 4 cycles.
REQ-034 SHALL cover: timeout build with TIMEOUT_CYC 16 and a slave that never asserts bvalid -> at cycle 16 bready drops, rsp_resp 2'b10, rsp_timeout 1.
REQ-035 SHALL cover: rst_n pulsed low while awvalid is high -> all outputs 0 the same cycle, state IDLE, no rsp_valid after release.
REQ-036 SHALL cover: back-to-back write 0x4 = 0x0, write 0x0 = 0x1, write 0x0 = 0x2 with rsp_ready tied 1 -> three B handshakes in order and no overlapping AXI valids.
